icmp_echo_rx: RTL and testbench
===============================

Name: icmp_echo_rx

Overview:
- GMII byte-stream receiver that parses preamble/SFD, Ethernet, IPv4 (with options) and ICMP headers, and accepts only echo requests addressed to the board.
- Streams the echo payload to a reply buffer.
- Captures requester MAC/IP, ID and sequence for the reply path.
- Verifies the ICMP checksum and reports a per-frame done/error verdict.
- Sits between the GMII RX adapter and the ICMP reply transmitter in the UDP/OSD Ethernet stack.

Parameters:
- BOARD_MAC, 48'h00_11_22_33_44_55, MAC address accepted as destination.
- BOARD_IP, {8'd192,8'd168,8'd1,8'd10}, IPv4 address accepted as destination.
- MAX_PAYLOAD, 1472, maximum echo payload bytes; larger frames are rejected.
- CHECK_CSUM, 1, 1 = a bad ICMP checksum yields rec_pkt_err; 0 = checksum is ignored.
- ACCEPT_BCAST, 1, 1 = destination MAC ff:ff:ff:ff:ff:ff is also accepted.

Ports:
- clk  in  1  system clock (GMII RX clock domain)
- resetn  in  1  reset; asynchronous, active-low
- gmii_rxd_valid  in  1  RX byte valid; stays high for the whole frame
- gmii_rxd_data  in  8  RX byte
- rec_en  out  1  payload byte strobe
- rec_data  out  8  payload byte
- rec_pkt_done  out  1  one-cycle pulse: frame accepted, checksum good
- rec_pkt_err  out  1  one-cycle pulse: frame rejected after payload streaming began; downstream discards the buffered bytes
- rec_byte_num  out  16  payload byte count, valid at rec_pkt_done
- src_mac  out  48  requester MAC
- src_ip  out  32  requester IP
- icmp_id  out  16  echo identifier
- icmp_seq  out  16  echo sequence number
- reply_checksum  out  32  unfolded sum of payload 16-bit words

Behaviour:
- Reset: every output is 0; state IDLE; all accumulators cleared. Asserting resetn mid-frame aborts the frame with no pulse.
- States: IDLE, PREAMBLE, ETH_HEAD, IP_HEAD, ICMP_HEAD, RX_DATA, WAIT_END, DROP.
- IDLE -> PREAMBLE on a valid 0x55.
- PREAMBLE: 6 further 0x55 bytes then 0xD5 -> ETH_HEAD; any other byte -> DROP.
- ETH_HEAD (14 bytes): capture dst MAC, src MAC and type. The destination must match (BOARD_MAC, or broadcast if ACCEPT_BCAST) and type must be 0x0800, else DROP.
- IP_HEAD:
  - Version must be 4 and IHL must be >= 5, else DROP.
  - Header length is IHL*4, 20..60 bytes; the byte counter is 6 bits wide.
  - Capture total_length, protocol (must be 1), src IP and dst IP (must equal BOARD_IP).
  - Skip options up to IHL*4.
  - Payload length = total_length - IHL*4 - 8. DROP if total_length < IHL*4+8 or payload > MAX_PAYLOAD.
- ICMP_HEAD (8 bytes): type must be 8 and code 0, else DROP. Capture checksum, id and seq; all 8 bytes enter the checksum accumulator.
- RX_DATA:
  - Each valid byte gives rec_en=1 and rec_data=byte on the next cycle (1-cycle latency).
  - Bytes pair big-endian into 16-bit words added to reply_checksum and the verify accumulator.
  - An odd final byte is padded as {byte,8'h00}.
  - After the last payload byte -> WAIT_END; rec_en drops on the following cycle.
  - gmii_rxd_valid falling before the payload is complete -> rec_pkt_err on the next cycle, then IDLE.
- Zero-length payload: RX_DATA is bypassed and rec_en never asserts.
- WAIT_END:
  - Ethernet padding and FCS bytes are ignored.
  - On the first cycle with valid=0, exactly one of rec_pkt_done / rec_pkt_err pulses, then IDLE.
  - The verify sum is folded end-around-carry into 16 bits; it must equal 0xFFFF when CHECK_CSUM=1, else rec_pkt_err.
  - rec_byte_num and reply_checksum update in the same cycle as rec_pkt_done and hold until the next accepted frame.
  - src_mac, src_ip, icmp_id and icmp_seq are held registers that change only on accepted frames; they are shadowed during parsing and committed at done.
- DROP: waits for valid=0 with no pulse (no payload was streamed), then IDLE.
- Back-to-back frames: a single valid=0 cycle between frames is sufficient.
- Widths: the verify accumulator is 32 bits (maximum sum below 2^27), folded twice. The payload counter is 16 bits.

Decomposition:
- Shared package eth_pkg: ETH_TYPE_IPV4=16'h0800, IP_PROTO_ICMP=8'd1, ICMP_ECHO_REQ=8'h08, ICMP_ECHO_REPLY=8'h00, PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5, and the state encoding.
- Sub-module ones_comp_acc: byte-pairing 16-bit word accumulator with clear, byte strobe and a last-odd flag. Outputs the raw 32-bit sum and the folded 16-bit sum. Two instances: one for verify (header + payload), one for reply_checksum (payload only).

Test Plan:
- Valid echo request to BOARD_MAC/BOARD_IP, IHL=5, payload 32 bytes 0x61..0x80, id=0x0001, seq=0x0007 -> 32 rec_en strobes in order, then rec_pkt_done with rec_byte_num=32, icmp_id=0x0001, icmp_seq=0x0007, src_ip = sender's address, reply_checksum = software reference sum.
- Same request with IHL=6 (4 option bytes) and a 33-byte odd payload -> payload correctly located; rec_byte_num=33; last word padded {byte,00}; rec_pkt_done.
- Corrupted ICMP checksum (+1), CHECK_CSUM=1 -> payload streamed, then rec_pkt_err and no rec_pkt_done; held icmp_id/seq/src_ip unchanged. Same frame with CHECK_CSUM=0 -> rec_pkt_done.
- Wrong dst IP, protocol=17, and ICMP type=0 frames -> no rec_en, no pulses; a following valid frame is accepted after a 1-cycle gap.
- Valid deasserted after 10 of 64 payload bytes -> rec_pkt_err one cycle later; next frame parsed normally.
- resetn asserted mid-payload, then a valid frame -> all outputs 0 during reset; next frame gives rec_pkt_done with correct values.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared Ethernet/IPv4/ICMP constants and the echo receiver state encoding.
package eth_pkg;

    localparam logic [15:0] ETH_TYPE_IPV4   = 16'h0800;
    localparam logic [7:0]  IP_PROTO_ICMP   = 8'd1;
    localparam logic [7:0]  ICMP_ECHO_REQ   = 8'h08;
    localparam logic [7:0]  ICMP_ECHO_REPLY = 8'h00;
    localparam logic [7:0]  PREAMBLE_BYTE   = 8'h55;
    localparam logic [7:0]  SFD_BYTE        = 8'hD5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_ETH_HEAD,
        ST_IP_HEAD,
        ST_ICMP_HEAD,
        ST_RX_DATA,
        ST_WAIT_END,
        ST_DROP
    } rx_state_e;

endpackage

// File: rtl/ones_comp_acc.sv
// Byte-pairing big-endian 16-bit word accumulator for internet checksums.
module ones_comp_acc (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [7:0]  byte_i,
    input  logic        last_i,
    output logic [31:0] sum_o,
    output logic [15:0] fold_o
);

    logic [31:0] sum_q, sum_d;
    logic [7:0]  hi_q, hi_d;
    logic        phase_q, phase_d;
    logic [16:0] fold1;
    logic [15:0] fold2;

    always_comb begin
        sum_d   = sum_q;
        hi_d    = hi_q;
        phase_d = phase_q;
        if (clr_i) begin
            sum_d   = '0;
            hi_d    = '0;
            phase_d = 1'b0;
        end else if (en_i) begin
            if (phase_q) begin
                sum_d   = sum_q + {16'h0, hi_q, byte_i};
                phase_d = 1'b0;
            end else if (last_i) begin
                // odd trailing byte is padded with a zero low byte
                sum_d = sum_q + {16'h0, byte_i, 8'h00};
            end else begin
                hi_d    = byte_i;
                phase_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            hi_q    <= '0;
            phase_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            hi_q    <= hi_d;
            phase_q <= phase_d;
        end
    end

    assign fold1  = {1'b0, sum_q[15:0]} + {1'b0, sum_q[31:16]};
    assign fold2  = fold1[15:0] + {15'h0, fold1[16]};
    assign sum_o  = sum_q;
    assign fold_o = fold2;

endmodule

// File: rtl/icmp_echo_rx.sv
// GMII receiver that accepts ICMP echo requests for this board and
// streams the echo payload with a per-frame done/error verdict.
module icmp_echo_rx
    import eth_pkg::*;
#(
    parameter logic [47:0] BOARD_MAC    = 48'h00_11_22_33_44_55,
    parameter logic [31:0] BOARD_IP     = {8'd192, 8'd168, 8'd1, 8'd10},
    parameter int          MAX_PAYLOAD  = 1472,
    parameter bit          CHECK_CSUM   = 1'b1,
    parameter bit          ACCEPT_BCAST = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        gmii_rxd_valid,
    input  logic [7:0]  gmii_rxd_data,
    output logic        rec_en,
    output logic [7:0]  rec_data,
    output logic        rec_pkt_done,
    output logic        rec_pkt_err,
    output logic [15:0] rec_byte_num,
    output logic [47:0] src_mac,
    output logic [31:0] src_ip,
    output logic [15:0] icmp_id,
    output logic [15:0] icmp_seq,
    output logic [31:0] reply_checksum
);

    rx_state_e   state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [15:0] pay_cnt_q, pay_cnt_d;
    logic [15:0] pay_len_q, pay_len_d;
    logic [3:0]  ihl_q, ihl_d;
    logic [15:0] tot_len_q, tot_len_d;
    logic [7:0]  proto_q, proto_d;
    logic [47:0] dst_mac_q, dst_mac_d;
    logic [7:0]  type_hi_q, type_hi_d;
    logic [23:0] dst_ip_q, dst_ip_d;
    logic [47:0] sh_mac_q, sh_mac_d;
    logic [31:0] sh_ip_q, sh_ip_d;
    logic [15:0] sh_id_q, sh_id_d;
    logic [15:0] sh_seq_q, sh_seq_d;

    logic        rec_en_q;
    logic [7:0]  rec_data_q;
    logic        done_q, err_q;
    logic [15:0] byte_num_q;
    logic [47:0] src_mac_q;
    logic [31:0] src_ip_q;
    logic [15:0] id_q, seq_q;
    logic [31:0] reply_q;

    logic        rec_en_d, done_d, err_d;
    logic        acc_clr, vfy_en, rep_en, last_byte;
    logic [31:0] vfy_sum, rep_sum;
    logic [15:0] vfy_fold, rep_fold;
    logic        unused_acc;

    logic        vld;
    logic [7:0]  d;
    logic [5:0]  hlen;
    logic [15:0] min_len, pay_len_c;
    logic        mac_ok, ip_ok, csum_ok;

    assign vld = gmii_rxd_valid;
    assign d   = gmii_rxd_data;

    assign hlen      = {ihl_q, 2'b00};
    assign min_len   = {10'd0, hlen} + 16'd8;
    assign pay_len_c = tot_len_q - min_len;

    assign mac_ok = (dst_mac_q == BOARD_MAC) ||
                    (ACCEPT_BCAST && (dst_mac_q == 48'hFFFF_FFFF_FFFF));
    assign ip_ok  = (proto_q == IP_PROTO_ICMP) &&
                    ({dst_ip_q, d} == BOARD_IP) &&
                    (tot_len_q >= min_len) &&
                    (pay_len_c <= 16'(MAX_PAYLOAD));
    assign csum_ok = !CHECK_CSUM || (vfy_fold == 16'hFFFF);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pay_cnt_d = pay_cnt_q;
        pay_len_d = pay_len_q;
        ihl_d     = ihl_q;
        tot_len_d = tot_len_q;
        proto_d   = proto_q;
        dst_mac_d = dst_mac_q;
        type_hi_d = type_hi_q;
        dst_ip_d  = dst_ip_q;
        sh_mac_d  = sh_mac_q;
        sh_ip_d   = sh_ip_q;
        sh_id_d   = sh_id_q;
        sh_seq_d  = sh_seq_q;
        rec_en_d  = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        acc_clr   = (state_q == ST_IDLE);
        vfy_en    = 1'b0;
        rep_en    = 1'b0;
        last_byte = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (vld) begin
                    cnt_d   = '0;
                    state_d = (d == PREAMBLE_BYTE) ? ST_PREAMBLE : ST_DROP;
                end
            end
            ST_PREAMBLE: begin
                if (!vld) begin
                    state_d = ST_IDLE;
                end else if (d == PREAMBLE_BYTE && cnt_q < 6'd6) begin
                    cnt_d = cnt_q + 6'd1;
                end else if (d == SFD_BYTE && cnt_q == 6'd6) begin
                    cnt_d   = '0;
                    state_d = ST_ETH_HEAD;
                end else begin
                    state_d = ST_DROP;
                end
            end
            ST_ETH_HEAD: begin
                if (!vld) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q < 6'd6) begin
                        dst_mac_d = {dst_mac_q[39:0], d};
                    end else if (cnt_q < 6'd12) begin
                        sh_mac_d = {sh_mac_q[39:0], d};
                    end else if (cnt_q == 6'd12) begin
                        type_hi_d = d;
                    end else begin
                        cnt_d = '0;
                        if (mac_ok && {type_hi_q, d} == ETH_TYPE_IPV4)
                            state_d = ST_IP_HEAD;
                        else
                            state_d = ST_DROP;
                    end
                end
            end
            ST_IP_HEAD: begin
                if (!vld) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                    case (cnt_q)
                        6'd0: begin
                            ihl_d = d[3:0];
                            if (d[7:4] != 4'd4 || d[3:0] < 4'd5)
                                state_d = ST_DROP;
                        end
                        6'd2: tot_len_d[15:8] = d;
                        6'd3: tot_len_d[7:0]  = d;
                        6'd9: proto_d = d;
                        6'd12, 6'd13, 6'd14, 6'd15:
                            sh_ip_d = {sh_ip_q[23:0], d};
                        6'd16, 6'd17, 6'd18:
                            dst_ip_d = {dst_ip_q[15:0], d};
                        6'd19: begin
                            pay_len_d = pay_len_c;
                            if (!ip_ok) begin
                                state_d = ST_DROP;
                            end else if (ihl_q == 4'd5) begin
                                cnt_d   = '0;
                                state_d = ST_ICMP_HEAD;
                            end
                        end
                        default: begin
                            // option bytes beyond the fixed header
                            if (cnt_q > 6'd19 && cnt_q == hlen - 6'd1) begin
                                cnt_d   = '0;
                                state_d = ST_ICMP_HEAD;
                            end
                        end
                    endcase
                end
            end
            ST_ICMP_HEAD: begin
                if (!vld) begin
                    state_d = ST_IDLE;
                end else begin
                    vfy_en = 1'b1;
                    cnt_d  = cnt_q + 6'd1;
                    case (cnt_q)
                        6'd0: if (d != ICMP_ECHO_REQ) state_d = ST_DROP;
                        6'd1: if (d != 8'h00) state_d = ST_DROP;
                        6'd4: sh_id_d[15:8]  = d;
                        6'd5: sh_id_d[7:0]   = d;
                        6'd6: sh_seq_d[15:8] = d;
                        6'd7: begin
                            sh_seq_d[7:0] = d;
                            pay_cnt_d     = '0;
                            state_d = (pay_len_q == 16'd0) ?
                                      ST_WAIT_END : ST_RX_DATA;
                        end
                        default: ;
                    endcase
                end
            end
            ST_RX_DATA: begin
                if (!vld) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    rec_en_d  = 1'b1;
                    vfy_en    = 1'b1;
                    rep_en    = 1'b1;
                    pay_cnt_d = pay_cnt_q + 16'd1;
                    last_byte = (pay_cnt_q == pay_len_q - 16'd1);
                    if (last_byte)
                        state_d = ST_WAIT_END;
                end
            end
            ST_WAIT_END: begin
                if (!vld) begin
                    state_d = ST_IDLE;
                    done_d  = csum_ok;
                    err_d   = !csum_ok;
                end
            end
            ST_DROP: begin
                if (!vld)
                    state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pay_cnt_q <= '0;
            pay_len_q <= '0;
            ihl_q     <= '0;
            tot_len_q <= '0;
            proto_q   <= '0;
            dst_mac_q <= '0;
            type_hi_q <= '0;
            dst_ip_q  <= '0;
            sh_mac_q  <= '0;
            sh_ip_q   <= '0;
            sh_id_q   <= '0;
            sh_seq_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pay_cnt_q <= pay_cnt_d;
            pay_len_q <= pay_len_d;
            ihl_q     <= ihl_d;
            tot_len_q <= tot_len_d;
            proto_q   <= proto_d;
            dst_mac_q <= dst_mac_d;
            type_hi_q <= type_hi_d;
            dst_ip_q  <= dst_ip_d;
            sh_mac_q  <= sh_mac_d;
            sh_ip_q   <= sh_ip_d;
            sh_id_q   <= sh_id_d;
            sh_seq_q  <= sh_seq_d;
        end
    end

    // reply-path fields only change when a frame is accepted
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rec_en_q   <= 1'b0;
            rec_data_q <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            byte_num_q <= '0;
            src_mac_q  <= '0;
            src_ip_q   <= '0;
            id_q       <= '0;
            seq_q      <= '0;
            reply_q    <= '0;
        end else begin
            rec_en_q <= rec_en_d;
            done_q   <= done_d;
            err_q    <= err_d;
            if (rec_en_d)
                rec_data_q <= d;
            if (done_d) begin
                byte_num_q <= pay_len_q;
                src_mac_q  <= sh_mac_q;
                src_ip_q   <= sh_ip_q;
                id_q       <= sh_id_q;
                seq_q      <= sh_seq_q;
                reply_q    <= rep_sum;
            end
        end
    end

    ones_comp_acc u_vfy (
        .clk    (clk),
        .rst_n  (resetn),
        .clr_i  (acc_clr),
        .en_i   (vfy_en),
        .byte_i (d),
        .last_i (last_byte),
        .sum_o  (vfy_sum),
        .fold_o (vfy_fold)
    );

    ones_comp_acc u_rep (
        .clk    (clk),
        .rst_n  (resetn),
        .clr_i  (acc_clr),
        .en_i   (rep_en),
        .byte_i (d),
        .last_i (last_byte),
        .sum_o  (rep_sum),
        .fold_o (rep_fold)
    );

    assign unused_acc = ^{vfy_sum, rep_fold};

    assign rec_en         = rec_en_q;
    assign rec_data       = rec_data_q;
    assign rec_pkt_done   = done_q;
    assign rec_pkt_err    = err_q;
    assign rec_byte_num   = byte_num_q;
    assign src_mac        = src_mac_q;
    assign src_ip         = src_ip_q;
    assign icmp_id        = id_q;
    assign icmp_seq       = seq_q;
    assign reply_checksum = reply_q;

endmodule

// File: tb/tb_icmp_echo_rx.sv
// Directed bench for icmp_echo_rx: two instances, checksum check on/off.
module tb_icmp_echo_rx;

    localparam logic [47:0] BMAC = 48'h00_11_22_33_44_55;
    localparam logic [47:0] SMAC = 48'h02_00_00_00_00_01;
    localparam logic [47:0] BCST = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [31:0] BIP  = 32'hC0A8010A;
    localparam logic [31:0] SIP1 = 32'hC0A80164;
    localparam logic [31:0] SIP2 = 32'hC0A80165;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        vld = 1'b0;
    logic [7:0]  dat = 8'h00;

    logic        en0, done0, err0;
    logic [7:0]  rd0;
    logic [15:0] bn0, id0, seq0;
    logic [47:0] mac0;
    logic [31:0] ip0, rc0;

    logic        en1, done1, err1;
    logic [7:0]  rd1;
    logic [15:0] bn1, id1, seq1;
    logic [47:0] mac1;
    logic [31:0] ip1, rc1;

    always #5 clk = ~clk;

    icmp_echo_rx dut (
        .clk            (clk),
        .resetn         (resetn),
        .gmii_rxd_valid (vld),
        .gmii_rxd_data  (dat),
        .rec_en         (en0),
        .rec_data       (rd0),
        .rec_pkt_done   (done0),
        .rec_pkt_err    (err0),
        .rec_byte_num   (bn0),
        .src_mac        (mac0),
        .src_ip         (ip0),
        .icmp_id        (id0),
        .icmp_seq       (seq0),
        .reply_checksum (rc0)
    );

    icmp_echo_rx #(.CHECK_CSUM(1'b0)) dut_nc (
        .clk            (clk),
        .resetn         (resetn),
        .gmii_rxd_valid (vld),
        .gmii_rxd_data  (dat),
        .rec_en         (en1),
        .rec_data       (rd1),
        .rec_pkt_done   (done1),
        .rec_pkt_err    (err1),
        .rec_byte_num   (bn1),
        .src_mac        (mac1),
        .src_ip         (ip1),
        .icmp_id        (id1),
        .icmp_seq       (seq1),
        .reply_checksum (rc1)
    );

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    int en_cnt = 0, done_cnt = 0, err_cnt = 0;
    int done1_cnt = 0, err1_cnt = 0;
    int en_cyc = 0, err_cyc = 0;
    logic [7:0] rx_q[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (en0) begin
            en_cnt++;
            rx_q.push_back(rd0);
            en_cyc = cyc;
        end
        if (done0) done_cnt++;
        if (err0) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (done1) done1_cnt++;
        if (err1) err1_cnt++;
    end

    int sn_en, sn_done, sn_err, sn_done1, sn_err1, sn_q;

    task automatic snap();
        sn_en    = en_cnt;
        sn_done  = done_cnt;
        sn_err   = err_cnt;
        sn_done1 = done1_cnt;
        sn_err1  = err1_cnt;
        sn_q     = rx_q.size();
    endtask

    function automatic int bad_bytes(input int n, input logic [7:0] p0);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            if (sn_q + i >= rx_q.size())
                bad++;
            else if (rx_q[sn_q + i] !== 8'(p0 + i))
                bad++;
        end
        return bad;
    endfunction

    logic [7:0] fr[$];

    task automatic build(input logic [47:0] dmac, input logic [31:0] dip,
                         input logic [7:0] proto, input logic [3:0] ihl,
                         input logic [7:0] ityp, input logic [15:0] id,
                         input logic [15:0] seq, input int plen,
                         input logic [7:0] p0, input logic [15:0] cdelta,
                         input logic [31:0] sip);
        logic [15:0] tl;
        logic [31:0] s;
        logic [16:0] f1;
        logic [15:0] f2, c;
        logic [7:0]  lo;
        int hl;
        hl = int'(ihl) * 4;
        tl = 16'(hl + 8 + plen);
        fr.delete();
        repeat (7) fr.push_back(8'h55);
        fr.push_back(8'hD5);
        for (int i = 0; i < 6; i++) fr.push_back(dmac[47 - 8*i -: 8]);
        for (int i = 0; i < 6; i++) fr.push_back(SMAC[47 - 8*i -: 8]);
        fr.push_back(8'h08);
        fr.push_back(8'h00);
        fr.push_back({4'h4, ihl});
        fr.push_back(8'h00);
        fr.push_back(tl[15:8]);
        fr.push_back(tl[7:0]);
        repeat (4) fr.push_back(8'h00);
        fr.push_back(8'd64);
        fr.push_back(proto);
        repeat (2) fr.push_back(8'h00);
        for (int i = 0; i < 4; i++) fr.push_back(sip[31 - 8*i -: 8]);
        for (int i = 0; i < 4; i++) fr.push_back(dip[31 - 8*i -: 8]);
        for (int i = 20; i < hl; i++) fr.push_back(8'h01);
        s = {16'h0, ityp, 8'h00} + {16'h0, id} + {16'h0, seq};
        for (int i = 0; i < plen; i += 2) begin
            lo = (i + 1 < plen) ? 8'(p0 + i + 1) : 8'h00;
            s = s + {16'h0, 8'(p0 + i), lo};
        end
        f1 = {1'b0, s[15:0]} + {1'b0, s[31:16]};
        f2 = f1[15:0] + {15'h0, f1[16]};
        c  = ~f2 + cdelta;
        fr.push_back(ityp);
        fr.push_back(8'h00);
        fr.push_back(c[15:8]);
        fr.push_back(c[7:0]);
        fr.push_back(id[15:8]);
        fr.push_back(id[7:0]);
        fr.push_back(seq[15:8]);
        fr.push_back(seq[7:0]);
        for (int i = 0; i < plen; i++) fr.push_back(8'(p0 + i));
        repeat (4) fr.push_back(8'hAA);
    endtask

    task automatic send(input int limit);
        for (int i = 0; i < fr.size() && i < limit; i++) begin
            @(posedge clk);
            #1;
            vld = 1'b1;
            dat = fr[i];
        end
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1;
        vld = 1'b0;
        dat = 8'h00;
        repeat (n - 1) @(posedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_en", {en0, done0, err0}, 0);
        chk("rst_bytenum", bn0, 0);
        chk("rst_srcmac", mac0, 0);
        chk("rst_ids", {ip0, id0, seq0}, 0);
        chk("rst_reply", rc0, 0);
        resetn = 1'b1;
        idle(2);

        // valid echo request, IHL=5, 32 bytes 0x61..0x80
        snap();
        build(BMAC, BIP, 8'd1, 4'd5, 8'h08, 16'h0001, 16'h0007,
              32, 8'h61, 16'h0, SIP1);
        send(1000);
        idle(4);
        chk("t1_strobes", en_cnt - sn_en, 32);
        chk("t1_data", bad_bytes(32, 8'h61), 0);
        chk("t1_done", done_cnt - sn_done, 1);
        chk("t1_err", err_cnt - sn_err, 0);
        chk("t1_bytenum", bn0, 32);
        chk("t1_id", id0, 16'h0001);
        chk("t1_seq", seq0, 16'h0007);
        chk("t1_srcip", ip0, SIP1);
        chk("t1_srcmac", mac0, SMAC);
        chk("t1_reply", rc0, 32'h0007_0710);

        // IHL=6 with options, odd 33-byte payload 0x61..0x81
        snap();
        build(BMAC, BIP, 8'd1, 4'd6, 8'h08, 16'h0002, 16'h0008,
              33, 8'h61, 16'h0, SIP1);
        send(1000);
        idle(4);
        chk("t2_strobes", en_cnt - sn_en, 33);
        chk("t2_data", bad_bytes(33, 8'h61), 0);
        chk("t2_done", done_cnt - sn_done, 1);
        chk("t2_bytenum", bn0, 33);
        chk("t2_reply", rc0, 32'h0007_8810);
        chk("t2_idseq", {id0, seq0}, 32'h0002_0008);

        // checksum off by one: rejected with checking, accepted without
        snap();
        build(BMAC, BIP, 8'd1, 4'd5, 8'h08, 16'h0003, 16'h0009,
              32, 8'h61, 16'h1, SIP2);
        send(1000);
        idle(4);
        chk("t3_strobes", en_cnt - sn_en, 32);
        chk("t3_err", err_cnt - sn_err, 1);
        chk("t3_nodone", done_cnt - sn_done, 0);
        chk("t3_held", {ip0, id0, seq0}, {SIP1, 16'h0002, 16'h0008});
        chk("t3_nc_done", done1_cnt - sn_done1, 1);
        chk("t3_nc_err", err1_cnt - sn_err1, 0);
        chk("t3_nc_id", {ip1, id1}, {SIP2, 16'h0003});

        // rejected frames back-to-back, then broadcast frame after 1 gap
        snap();
        build(BMAC, 32'hC0A8010B, 8'd1, 4'd5, 8'h08, 16'h0009,
              16'h0009, 16, 8'h20, 16'h0, SIP1);
        send(1000);
        idle(1);
        build(BMAC, BIP, 8'd17, 4'd5, 8'h08, 16'h0009, 16'h0009,
              16, 8'h20, 16'h0, SIP1);
        send(1000);
        idle(1);
        build(BMAC, BIP, 8'd1, 4'd5, 8'h00, 16'h0009, 16'h0009,
              16, 8'h20, 16'h0, SIP1);
        send(1000);
        idle(1);
        chk("t4_rej_strobes", en_cnt - sn_en, 0);
        chk("t4_rej_pulses", (done_cnt - sn_done) + (err_cnt - sn_err), 0);
        build(BCST, BIP, 8'd1, 4'd5, 8'h08, 16'h0004, 16'h000A,
              32, 8'h61, 16'h0, SIP1);
        send(1000);
        idle(4);
        chk("t4_strobes", en_cnt - sn_en, 32);
        chk("t4_done", done_cnt - sn_done, 1);
        chk("t4_err", err_cnt - sn_err, 0);
        chk("t4_idseq", {id0, seq0}, 32'h0004_000A);

        // valid drops after 10 of 64 payload bytes
        snap();
        build(BMAC, BIP, 8'd1, 4'd5, 8'h08, 16'h0005, 16'h0005,
              64, 8'h00, 16'h0, SIP2);
        send(60);
        idle(4);
        chk("t5_strobes", en_cnt - sn_en, 10);
        chk("t5_data", bad_bytes(10, 8'h00), 0);
        chk("t5_err", err_cnt - sn_err, 1);
        chk("t5_err_lat", err_cyc - en_cyc, 1);
        chk("t5_nodone", done_cnt - sn_done, 0);
        chk("t5_held_bn", bn0, 32);
        snap();
        build(BMAC, BIP, 8'd1, 4'd5, 8'h08, 16'h0006, 16'h000B,
              20, 8'h30, 16'h0, SIP2);
        send(1000);
        idle(4);
        chk("t5_next_done", done_cnt - sn_done, 1);
        chk("t5_next_bn", bn0, 20);
        chk("t5_next_ip", ip0, SIP2);

        // reset mid-payload, then a clean frame
        build(BMAC, BIP, 8'd1, 4'd5, 8'h08, 16'h0007, 16'h0007,
              64, 8'h10, 16'h0, SIP2);
        send(60);
        #2;
        resetn = 1'b0;
        vld = 1'b0;
        dat = 8'h00;
        snap();
        repeat (3) @(posedge clk);
        #1;
        chk("t6_rst_out", {en0, done0, err0, bn0}, 0);
        chk("t6_rst_hold", {ip0, id0, seq0}, 0);
        chk("t6_rst_reply", rc0, 0);
        chk("t6_rst_pulses", (done_cnt - sn_done) + (err_cnt - sn_err), 0);
        resetn = 1'b1;
        idle(2);
        snap();
        build(BMAC, BIP, 8'd1, 4'd5, 8'h08, 16'h0008, 16'h000C,
              32, 8'h61, 16'h0, SIP1);
        send(1000);
        idle(4);
        chk("t6_done", done_cnt - sn_done, 1);
        chk("t6_err", err_cnt - sn_err, 0);
        chk("t6_idseq", {id0, seq0}, 32'h0008_000C);
        chk("t6_bn_reply", {bn0, rc0}, {16'd32, 32'h0007_0710});
        chk("t6_srcip", ip0, SIP1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
